// File: rtl/i2s_tx_engine.sv
// I2S transmitter: stereo sample FIFO feeding a 2*SLOT_W-bit shift frame.
// Drives MCLK, BCLK, LRCLK and one-bit-delayed serial data for a codec.
module i2s_tx_engine #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int MCLK_DIV   = 4,
    parameter int BCLK_DIV   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset,
    input  logic                                enable,
    input  logic                                mono,
    input  logic [2*SAMPLE_W-1:0]               sample_data,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    input  logic                                underrun_clr,
    output logic                                aud_mclk,
    output logic                                aud_bclk,
    output logic                                aud_lrclk,
    output logic                                aud_dacdat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic                                underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int KW      = $clog2(FRAME_W);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);
    localparam int MW      = $clog2(MCLK_DIV);
    localparam int BW      = $clog2(BCLK_DIV);

    logic [MW-1:0]          mcnt;
    logic [BW-1:0]          bcnt;
    logic [KW-1:0]          k, k_next;
    logic                   running;
    logic [FRAME_W-1:0]     frame, frame_new;
    logic [SLOT_W-1:0]      slot_l, slot_r;
    logic [SAMPLE_W-1:0]    head_l, head_r;

    logic [2*SAMPLE_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr, rptr;
    logic                   full, empty, wr_en, pop;
    logic                   half_wrap, fall_tick, load;

    // MCLK free-runs regardless of enable
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mcnt     <= '0;
            aud_mclk <= 1'b0;
        end else if (mcnt == MW'(MCLK_DIV/2 - 1)) begin
            mcnt     <= '0;
            aud_mclk <= ~aud_mclk;
        end else begin
            mcnt <= mcnt + MW'(1);
        end
    end

    assign full         = (fifo_level == LW'(FIFO_DEPTH));
    assign empty        = (fifo_level == '0);
    assign sample_ready = ~full;
    assign wr_en        = sample_valid & ~full;

    assign half_wrap = (bcnt == BW'(BCLK_DIV/2 - 1));
    assign fall_tick = enable & aud_bclk & half_wrap;
    // first tick after enable always enters k=0 so it loads a frame
    assign k_next    = (!running || k == KW'(FRAME_W - 1)) ? '0 : k + KW'(1);
    assign load      = fall_tick & (k_next == '0);
    // empty is evaluated before this cycle's write, so no bypass on load
    assign pop       = load & ~empty;

    assign head_l = mem[rptr][2*SAMPLE_W-1:SAMPLE_W];
    assign head_r = mem[rptr][SAMPLE_W-1:0];

    always_comb begin
        slot_l = '0;
        slot_r = '0;
        slot_l[SLOT_W-1 -: SAMPLE_W] = head_l;
        slot_r[SLOT_W-1 -: SAMPLE_W] = mono ? head_l : head_r;
        frame_new = empty ? '0 : {slot_l, slot_r};
    end

    always_ff @(posedge clk_clk) begin
        if (wr_en)
            mem[wptr] <= sample_data;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (pop)   rptr <= rptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // serial side; dropping enable aborts the frame in flight
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bcnt       <= '0;
            aud_bclk   <= 1'b0;
            k          <= '0;
            running    <= 1'b0;
            aud_lrclk  <= 1'b0;
            aud_dacdat <= 1'b0;
            frame      <= '0;
        end else if (!enable) begin
            bcnt       <= '0;
            aud_bclk   <= 1'b0;
            k          <= '0;
            running    <= 1'b0;
            aud_lrclk  <= 1'b0;
            aud_dacdat <= 1'b0;
            frame      <= '0;
        end else begin
            if (half_wrap) begin
                bcnt     <= '0;
                aud_bclk <= ~aud_bclk;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
            if (fall_tick) begin
                running    <= 1'b1;
                k          <= k_next;
                aud_lrclk  <= (k_next >= KW'(SLOT_W));
                // MSB before shift gives the one-BCLK I2S delay
                aud_dacdat <= frame[FRAME_W-1];
                frame      <= load ? frame_new : {frame[FRAME_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            underrun <= 1'b0;
        else if (load && empty)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end

endmodule
